mul_issue_arbiter: RTL and testbench
====================================

MUL_ISSUE_ARBITER -- requirements
Module: mul_issue_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width of the shared multiplier.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter LATENCY, default 6, fixed multiplier cycles from operands presented to product valid (>=1).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port enable, input, 1, permits new issues when high.
REQ-007 SHALL have port req_valid, input, NREQ, per-requester operand pair valid.
REQ-008 SHALL have port req_ready, output, NREQ, per-requester accept.
REQ-009 SHALL have port req_a, input, NREQ*WIDTH, operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port req_b, input, NREQ*WIDTH, operand B, same packing.
REQ-011 SHALL have port mul_a, output, WIDTH, registered operand A to multiplier.
REQ-012 SHALL have port mul_b, output, WIDTH, registered operand B to multiplier.
REQ-013 SHALL have port mul_result, input, 2*WIDTH, multiplier product.
REQ-014 SHALL have port rsp_valid, output, NREQ, one-hot product-return strobe.
REQ-015 SHALL have port rsp_data, output, 2*WIDTH, product returned.
REQ-016 SHALL have port busy, output, 1, high when any product in flight or state not IDLE.

Function
REQ-017 States: IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when in-flight count=0; DRAIN->RUN when enable=1 again.
REQ-018 req_ready SHALL be combinational, at most one bit high, and only in RUN.
REQ-019 Grant: round-robin; search starts at last granted index+1 modulo NREQ; first requester with req_valid=1 wins.
REQ-020 Handshake = req_valid[i] & req_ready[i]; on handshake last-grant pointer updates to i.
REQ-021 Handshake in cycle t: mul_a/mul_b SHALL hold req_a/req_b of i from cycle t+1; held unchanged when no issue.
REQ-022 Tag pipeline: LATENCY-deep shift of {valid, index}; entry enters at t+1.
REQ-023 rsp_valid[i] SHALL be high exactly in cycle t+1+LATENCY for a handshake at t; rsp_data = mul_result in that cycle; otherwise rsp_data = 0.
REQ-024 No return backpressure; every accepted request yields exactly one response, in issue order.
REQ-025 Throughput: one issue per cycle sustained; a single requester held valid is granted every cycle if alone.
REQ-026 In-flight counter width clog2(LATENCY+2); increments on issue, decrements on response, unchanged when both; never overflows (max LATENCY+1).
REQ-027 DRAIN: no new grants; outstanding products still returned.
REQ-028 enable falling in the same cycle as a handshake: handshake completes (ready was already high), then DRAIN.

Reset
REQ-029 On rst: state=IDLE, last-grant pointer=NREQ-1 (requester 0 first priority), tag pipeline cleared, in-flight count=0, mul_a=mul_b=0.
REQ-030 During and after rst: req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
REQ-031 rst mid-operation discards all in-flight tags; no rsp_valid for products issued before rst.

Verification
REQ-032 Single: enable=1, only req 2 valid, a=7, b=9, handshake t -> rsp_valid=4'b0100, rsp_data=63 at t+7 (LATENCY=6).
REQ-033 Fairness: all 4 valid continuously from reset -> grants 0,1,2,3,0,... one per cycle; responses in same order.
REQ-034 Drain: 3 issues, then enable=0 -> req_ready=0 next cycle, 3 responses still arrive, busy falls after last, state IDLE.
REQ-035 Reset mid-flight: 2 products issued, rst pulsed 1 cycle before first return -> no rsp_valid ever, busy=0, mul_a=0.
REQ-036 Boundary: a=b=32'hFFFFFFFF -> rsp_data=64'hFFFFFFFE00000001; LATENCY=1 build yields response at t+2.
REQ-037 Skip: req 0 and 3 valid, last grant 0 -> req 3 granted, then req 0.

Source files
------------

// File: rtl/mul_issue_arbiter.sv
// Round-robin issue arbiter in front of a shared, fixed-latency pipelined multiplier.
// Grants one requester per cycle, registers its operands and routes the product back by tag.
module mul_issue_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_result,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]    rsp_data,
  output logic                  busy
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic            issue_vld_q, issue_vld_d;
  logic [IdxW-1:0] issue_idx_q, issue_idx_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IdxW-1:0] tag_idx_q [LATENCY];
  logic [IdxW-1:0] tag_idx_d [LATENCY];
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            gnt_found;
  logic [IdxW-1:0] gnt_idx;
  logic [31:0]     cand;
  logic            issue;
  logic            resp_vld;
  logic [IdxW-1:0] resp_idx;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_q) + k) % NREQ;
      if (!gnt_found && req_valid[IdxW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IdxW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready depends on state only, so a handshake completes even if enable drops that cycle.
  assign issue = (state_q == StRun) && gnt_found;

  always_comb begin
    req_ready = '0;
    if (issue) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign resp_vld = tag_vld_q[LATENCY-1];
  assign resp_idx = tag_idx_q[LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    if (resp_vld) begin
      rsp_valid[resp_idx] = 1'b1;
    end
  end

  assign rsp_data = resp_vld ? mul_result : '0;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign busy     = (state_q != StIdle) || (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StDrain;
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_d      = issue ? gnt_idx : last_q;
    mul_a_d     = issue ? sel_a : mul_a_q;
    mul_b_d     = issue ? sel_b : mul_b_q;
    issue_vld_d = issue;
    issue_idx_d = gnt_idx;
  end

  // The issue register lines the tag up with the operands; the shift then spans LATENCY cycles.
  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = issue_vld_q;
    for (int k = 0; k < LATENCY; k++) begin
      tag_idx_d[k] = issue_idx_q;
    end
    for (int k = 1; k < LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({issue, resp_vld})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= IdxW'(NREQ - 1);
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      issue_vld_q <= 1'b0;
      issue_idx_q <= '0;
      tag_vld_q   <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_idx_q[k] <= '0;
      end
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      issue_vld_q <= issue_vld_d;
      issue_idx_q <= issue_idx_d;
      tag_vld_q   <= tag_vld_d;
      for (int k = 0; k < LATENCY; k++) begin
        tag_idx_q[k] <= tag_idx_d[k];
      end
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Bench for mul_issue_arbiter: a LATENCY=6 and a LATENCY=1 instance share stimulus and are
// compared against a queue-based reference of grants and product returns.
module tb_mul_issue_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 6;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;

  logic [NREQ-1:0] req_ready, rsp_valid, req_ready1, rsp_valid1;
  logic [W-1:0]    mul_a, mul_b, mul_a1, mul_b1;
  logic [2*W-1:0]  mul_result, rsp_data, mul_result1, rsp_data1;
  logic            busy, busy1;

  always #5 clk = ~clk;

  mul_issue_arbiter #(.WIDTH(W), .NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  mul_issue_arbiter #(.WIDTH(W), .NREQ(NREQ), .LATENCY(LAT1)) dut_l1 (
    .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_ready(req_ready1),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a1), .mul_b(mul_b1), .mul_result(mul_result1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1)
  );

  // Multiplier models: product of operands seen L cycles earlier.
  logic [63:0] hist [LAT];
  logic [63:0] hist1 [LAT1];
  always @(posedge clk) begin
    hist[0] <= {32'b0, mul_a} * {32'b0, mul_b};
    for (int k = 1; k < LAT; k++) hist[k] <= hist[k-1];
    hist1[0] <= {32'b0, mul_a1} * {32'b0, mul_b1};
  end
  assign mul_result  = hist[LAT-1];
  assign mul_result1 = hist1[0];

  typedef struct {
    int          due;
    int          idx;
    logic [63:0] prod;
  } rsp_t;

  rsp_t q6[$];
  rsp_t q1[$];
  int   cyc, m_mode, m_last, hs_idx;
  logic [31:0] m_a, m_b;
  int   vectors, miscompares;

  logic [3:0]  obs_ready, exp_ready, obs_rsp, exp_rsp, obs_rsp1, exp_rsp1;
  logic [63:0] obs_data, exp_data, obs_data1, exp_data1;
  logic        obs_busy, exp_busy, obs_hs;
  logic [31:0] obs_ma, obs_mb, exp_ma, exp_mb;

  // One clock: sample at the falling edge, advance the reference, return just after rising edge.
  task automatic step();
    int g, infl, j;
    logic [31:0] op_a, op_b;
    rsp_t e;
    @(negedge clk);
    obs_ready = req_ready;  obs_rsp = rsp_valid;   obs_data = rsp_data;
    obs_rsp1  = rsp_valid1; obs_data1 = rsp_data1; obs_busy = busy;
    obs_ma    = mul_a;      obs_mb = mul_b;
    obs_hs    = |(req_ready & req_valid);
    exp_ready = '0; exp_rsp = '0; exp_data = '0; exp_rsp1 = '0; exp_data1 = '0;
    exp_busy  = 1'b0; exp_ma = '0; exp_mb = '0;
    hs_idx    = -1;
    if (rst) begin
      m_mode = 0; m_last = NREQ - 1; m_a = '0; m_b = '0;
      q6.delete(); q1.delete();
    end else begin
      infl = q6.size();
      g = -1;
      if (m_mode == 1) begin
        for (int k = 1; k <= NREQ; k++) begin
          j = (m_last + k) % NREQ;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      if (q6.size() != 0 && q6[0].due == cyc) begin
        exp_rsp[q6[0].idx] = 1'b1; exp_data = q6[0].prod; void'(q6.pop_front());
      end
      if (q1.size() != 0 && q1[0].due == cyc) begin
        exp_rsp1[q1[0].idx] = 1'b1; exp_data1 = q1[0].prod; void'(q1.pop_front());
      end
      exp_busy = (m_mode != 0) || (infl != 0);
      exp_ma = m_a; exp_mb = m_b;
      if (g >= 0) begin
        hs_idx = g;
        op_a = req_a[g*W +: W];
        op_b = req_b[g*W +: W];
        e.idx = g; e.prod = {32'b0, op_a} * {32'b0, op_b};
        e.due = cyc + 1 + LAT;  q6.push_back(e);
        e.due = cyc + 1 + LAT1; q1.push_back(e);
        m_a = op_a; m_b = op_b; m_last = g;
      end
      case (m_mode)
        0: if (enable) m_mode = 1;
        1: if (!enable) m_mode = 2;
        default: begin
          if (enable) m_mode = 1;
          else if (infl == 0) m_mode = 0;
        end
      endcase
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; req_valid = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_hs(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      step();
      if (obs_hs) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; req_valid = '1;
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({obs_ready, obs_rsp, obs_busy} !== 9'b0 || obs_data !== 64'd0 || obs_ma !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_outputs ready=%b rsp=%b busy=%b data=%h mul_a=%h want all zero",
                 obs_ready, obs_rsp, obs_busy, obs_data, obs_ma);
      end
    end
    rst = 1'b0; enable = 1'b0; req_valid = '0;
    step();
    vectors++;
    if (obs_busy !== 1'b0 || obs_ready !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_release busy=%b ready=%b want 0 0", obs_busy, obs_ready);
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    enable = 1'b1; req_valid = 4'b0100;
    req_a = '0; req_b = '0;
    req_a[2*W +: W] = 32'd7; req_b[2*W +: W] = 32'd9;
    wait_hs(10, ok);
    vectors++;
    if (!ok || obs_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_grant ready=%b want 0100 (seen=%0d)", obs_ready, ok);
    end
    req_valid = '0;
    for (int j = 1; j <= LAT + 1; j++) begin
      step();
      if (j == 1) begin
        vectors++;
        if (obs_ma !== 32'd7 || obs_mb !== 32'd9) begin
          miscompares++;
          $display("FAIL single_operands mul_a=%0d mul_b=%0d want 7 9", obs_ma, obs_mb);
        end
      end
      vectors++;
      if (j == LAT + 1 && (obs_rsp !== 4'b0100 || obs_data !== 64'd63)) begin
        miscompares++;
        $display("FAIL single_rsp rsp=%b data=%0d want 0100 63", obs_rsp, obs_data);
      end else if (j < LAT + 1 && obs_rsp !== 4'b0) begin
        miscompares++;
        $display("FAIL single_early rsp=%b at +%0d want 0000", obs_rsp, j);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_fairness();
    int n, r;
    logic [3:0] want;
    do_reset();
    enable = 1'b1; req_valid = 4'b1111;
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    n = 0; r = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (k > 0) begin
        want = 4'b0001 << (n % 4);
        vectors++;
        if (obs_ready !== want) begin
          miscompares++;
          $display("FAIL fair_grant ready=%b want %b (issue %0d)", obs_ready, want, n);
        end
        n++;
      end
      if (exp_rsp != 4'b0) begin
        want = 4'b0001 << (r % 4);
        vectors++;
        if (obs_rsp !== want || obs_data !== exp_data) begin
          miscompares++;
          $display("FAIL fair_rsp rsp=%b data=%h want %b %h", obs_rsp, obs_data, want, exp_data);
        end
        r++;
      end
    end
    enable = 1'b0; req_valid = '0;
    for (int k = 0; k < 12; k++) step();
  endtask

  task automatic test_drain();
    int n, nrsp;
    bit idle;
    do_reset();
    enable = 1'b1; req_valid = 4'b0001;
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    for (int k = 0; k < 12 && n < 3; k++) begin
      if (n == 2) enable = 1'b0;
      step();
      if (obs_hs) n++;
    end
    vectors++;
    if (n != 3) begin
      miscompares++;
      $display("FAIL drain_issues got %0d want 3", n);
    end
    step();
    vectors++;
    if (obs_ready !== 4'b0 || obs_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_ready ready=%b busy=%b want 0000 1", obs_ready, obs_busy);
    end
    req_valid = '0; nrsp = 0; idle = 1'b0;
    for (int k = 0; k < 20 && !idle; k++) begin
      step();
      if (obs_rsp != 4'b0) nrsp++;
      vectors++;
      if (obs_rsp !== exp_rsp || obs_data !== exp_data || obs_busy !== exp_busy) begin
        miscompares++;
        $display("FAIL drain_rsp rsp=%b data=%h busy=%b want %b %h %b",
                 obs_rsp, obs_data, obs_busy, exp_rsp, exp_data, exp_busy);
      end
      if (obs_busy === 1'b0) idle = 1'b1;
    end
    vectors++;
    if (nrsp != 3 || !idle) begin
      miscompares++;
      $display("FAIL drain_done responses=%0d idle=%0d want 3 1", nrsp, idle);
    end
    req_valid = 4'b1111;
    step();
    vectors++;
    if (obs_ready !== 4'b0 || obs_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_idle ready=%b busy=%b want 0000 0", obs_ready, obs_busy);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_midflight();
    int n;
    do_reset();
    enable = 1'b1; req_valid = 4'b0010;
    req_a = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    req_b = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    for (int k = 0; k < 10 && n < 2; k++) begin
      step();
      if (obs_hs) n++;
    end
    req_valid = '0; enable = 1'b0;
    for (int k = 0; k < LAT - 3; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      vectors++;
      if (obs_rsp !== 4'b0 || obs_busy !== 1'b0 || obs_ma !== 32'd0) begin
        miscompares++;
        $display("FAIL midflight rsp=%b busy=%b mul_a=%h want 0000 0 0", obs_rsp, obs_busy, obs_ma);
      end
    end
  endtask

  task automatic test_boundary();
    bit ok;
    do_reset();
    enable = 1'b1; req_valid = 4'b0001;
    req_a = '1; req_b = '1;
    wait_hs(10, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bound_grant no handshake within 10 cycles");
    end
    req_valid = '0;
    for (int j = 1; j <= LAT + 1; j++) begin
      step();
      if (j == 1) begin
        vectors++;
        if (obs_rsp1 !== 4'b0) begin
          miscompares++;
          $display("FAIL bound_l1_early rsp=%b want 0000", obs_rsp1);
        end
      end
      if (j == 2) begin
        vectors++;
        if (obs_rsp1 !== 4'b0001 || obs_data1 !== 64'hFFFFFFFE00000001) begin
          miscompares++;
          $display("FAIL bound_l1_rsp rsp=%b data=%h want 0001 fffffffe00000001",
                   obs_rsp1, obs_data1);
        end
      end
      if (j == LAT + 1) begin
        vectors++;
        if (obs_rsp !== 4'b0001 || obs_data !== 64'hFFFFFFFE00000001) begin
          miscompares++;
          $display("FAIL bound_rsp rsp=%b data=%h want 0001 fffffffe00000001", obs_rsp, obs_data);
        end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_skip();
    bit ok;
    do_reset();
    enable = 1'b1; req_valid = 4'b0001;
    wait_hs(10, ok);
    req_valid = 4'b1001;
    step();
    vectors++;
    if (!ok || obs_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL skip_first ready=%b want 1000", obs_ready);
    end
    step();
    vectors++;
    if (obs_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL skip_second ready=%b want 0001", obs_ready);
    end
    req_valid = '0; enable = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 420; k++) begin
      if (k < 400) begin
        req_valid = 4'($urandom);
        enable    = ($urandom_range(0, 9) != 0);
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        req_valid = '0; enable = 1'b0;
      end
      step();
      vectors++;
      if (obs_ready !== exp_ready || obs_busy !== exp_busy) begin
        miscompares++;
        $display("FAIL rand_ctrl cyc=%0d ready=%b busy=%b want %b %b",
                 cyc, obs_ready, obs_busy, exp_ready, exp_busy);
      end
      vectors++;
      if (obs_ma !== exp_ma || obs_mb !== exp_mb) begin
        miscompares++;
        $display("FAIL rand_ops cyc=%0d mul_a=%h mul_b=%h want %h %h",
                 cyc, obs_ma, obs_mb, exp_ma, exp_mb);
      end
      vectors++;
      if (obs_rsp !== exp_rsp || obs_data !== exp_data) begin
        miscompares++;
        $display("FAIL rand_rsp cyc=%0d rsp=%b data=%h want %b %h",
                 cyc, obs_rsp, obs_data, exp_rsp, exp_data);
      end
      vectors++;
      if (obs_rsp1 !== exp_rsp1 || obs_data1 !== exp_data1) begin
        miscompares++;
        $display("FAIL rand_rsp_l1 cyc=%0d rsp=%b data=%h want %b %h",
                 cyc, obs_rsp1, obs_data1, exp_rsp1, exp_data1);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    m_mode = 0; m_last = NREQ - 1; m_a = '0; m_b = '0;
    rst = 1'b1; enable = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_drain();
    test_reset_midflight();
    test_boundary();
    test_skip();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
